// File: rtl/microtile_mon_pkg.sv
// Shared types and line levels for the microtile output monitor.
package microtile_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/mon_fifo.sv
// Small circular FIFO with extra-MSB pointers; a pop on an empty FIFO with a
// concurrent push passes the write data straight through.
module mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A same-cycle pop frees the slot a full push needs, and a same-cycle push
  // supplies the word an empty pop needs.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);

  assign rdata = empty ? wdata : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/microtile_out_monitor.sv
// Watches a tile's 8-bit output bus, queues each new value and serialises it
// as 8N1 frames on tx (LSB first).
module microtile_out_monitor
  import microtile_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] tile_out,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam logic [7:0] CNT_MAX  = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [7:0] sync1_q;
  logic [7:0] sync_q;
  logic [7:0] last_q;
  logic       push;
  logic       pop;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic       overflow_q;

  tx_state_t  state;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift_q;
  logic       bit_end;

  assign push = ena && (sync_q != last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q <= tile_out;
      sync_q  <= sync1_q;
      // last_q follows even when the push is dropped, so queued values always differ
      if (push) last_q <= sync_q;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  mon_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(sync_q),
    .pop  (pop),
    .rdata(rdata),
    .full (full),
    .empty(empty)
  );

  assign bit_end = (cnt == CNT_MAX);
  assign pop = !empty && ((state == IDLE) || (state == STOP && bit_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift_q <= '0;
    end else begin
      if (pop) shift_q <= rdata;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!empty) state <= START;
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            idx   <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == LAST_BIT) state <= STOP;
            else                 idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= empty ? IDLE : START;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx = IDLE_LEVEL;
    case (state)
      START:   tx = START_LEVEL;
      DATA:    tx = shift_q[idx];
      STOP:    tx = STOP_LEVEL;
      default: tx = IDLE_LEVEL;
    endcase
  end

  assign busy     = (state != IDLE) || !empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_microtile_out_monitor.sv
// Directed bench for microtile_out_monitor with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_microtile_out_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] tile_out = 8'h00;
  logic       tx;
  logic       busy;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  microtile_out_monitor #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .tile_out(tile_out),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tile_out = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_overflow", overflow, 0);
    rst_n = 1'b1;
  endtask

  // Returns after the last stop-bit cycle, so a back-to-back frame starts on the next negedge.
  task automatic rx_frame(input logic [7:0] exp, output int start_cyc);
    int waited = 0;
    logic [7:0] d;
    @(negedge clk);
    while (tx !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_val("rx_start_seen", tx == 1'b0, 1);
    start_cyc = cyc;
    repeat (2) @(negedge clk);
    check_val("rx_start_bit", tx, 0);
    for (int b = 0; b < 8; b++) begin
      repeat (4) @(negedge clk);
      d[b] = tx;
    end
    repeat (4) @(negedge clk);
    check_val("rx_stop_bit", tx, 1);
    @(negedge clk);
    check_val("rx_data", d, exp);
    $display("rx frame data=%02h expected=%02h start_cycle=%0d", d, exp, start_cyc);
  endtask

  task automatic quiet_window(input string tag, input int n);
    logic low_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check_val(tag, low_seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, s3, s;
    logic [9:0] fbits;
    logic [7:0] vals [8];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // 1: quiet bus after reset
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 24) begin
        check_val("t1_tx", tx, 1);
        check_val("t1_busy", busy, 0);
        check_val("t1_overflow", overflow, 0);
      end
    end

    // 2: single change 0xA5, checked every cycle; frame = start, LSB-first data, stop
    fbits = {1'b1, 8'hA5, 1'b0};
    tile_out = 8'hA5;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k < 3 || k > 42) check_val("t2_tx_idle", tx, 1);
      else                 check_val("t2_tx_frame", tx, fbits[(k - 3) / 4]);
      check_val("t2_busy", busy, (k >= 2 && k <= 42) ? 1 : 0);
    end
    check_val("t2_overflow", overflow, 0);
    $display("t2 single frame 0xA5 done");

    // 3: three changes 5 cycles apart -> contiguous frames
    fork
      begin
        tile_out = 8'h01;
        repeat (5) @(negedge clk);
        tile_out = 8'h02;
        repeat (5) @(negedge clk);
        tile_out = 8'h03;
      end
      begin
        rx_frame(8'h01, s1);
        rx_frame(8'h02, s2);
        rx_frame(8'h03, s3);
      end
    join
    check_val("t3_gap12", s2 - s1, 40);
    check_val("t3_gap23", s3 - s2, 40);
    check_val("t3_overflow", overflow, 0);
    @(negedge clk);
    check_val("t3_busy_end", busy, 0);

    // 4: 0x40 starts a frame, then eight values 10 cycles apart; 0x11..0x55 fit, rest dropped
    fork
      begin
        tile_out = 8'h40;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          if (k == 5) check_val("t4_overflow_before_drop", overflow, 0);
          tile_out = vals[k];
          repeat (10) @(negedge clk);
        end
      end
      begin
        rx_frame(8'h40, s1);
        for (int k = 0; k < 5; k++) begin
          rx_frame(vals[k], s);
          check_val("t4_contiguous", s - s1, 40 * (k + 1));
        end
      end
    join
    @(negedge clk);
    check_val("t4_busy_end", busy, 0);
    check_val("t4_overflow_set", overflow, 1);
    quiet_window("t4_no_extra_frame", 60);
    check_val("t4_overflow_sticky", overflow, 1);

    // 5: capture disabled, then re-enabled
    do_reset();
    ena = 1'b0;
    tile_out = 8'h3C;
    quiet_window("t5_disabled_quiet", 30);
    check_val("t5_busy_disabled", busy, 0);
    ena = 1'b1;
    rx_frame(8'h3C, s);
    quiet_window("t5_single_frame", 50);
    check_val("t5_busy_end", busy, 0);

    // 6: reset during DATA bit 3 of 0x5A with two entries queued
    do_reset();
    tile_out = 8'h5A;
    repeat (5) @(negedge clk);
    tile_out = 8'h11;
    repeat (5) @(negedge clk);
    tile_out = 8'h22;
    repeat (7) @(negedge clk);
    check_val("t6_bit2", tx, 0);
    check_val("t6_busy_mid", busy, 1);
    repeat (4) @(negedge clk);
    check_val("t6_bit3", tx, 1);
    #2;
    rst_n = 1'b0;
    tile_out = 8'h00;
    #1;
    check_val("t6_async_tx", tx, 1);
    check_val("t6_async_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_window("t6_no_frame_after_reset", 60);
    check_val("t6_busy_after", busy, 0);
    tile_out = 8'h77;
    rx_frame(8'h77, s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/microtile_out_monitor.md
# microtile_out_monitor

- On-chip reader for a microtile's 8-bit `uo_out` bus.
- Synchronises the bus and detects value changes. Each new value goes into a small FIFO and is sent out on a single UART-style serial line.
- Bench and silicon can therefore log every output transition of a tile without sampling all 8 pins directly.
- Sits beside the tile under observation in the microtile collection, fed from that tile's output bus.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range 2..255.
- `FIFO_DEPTH`, default 4: number of entries in the change FIFO. Must be a power of two, 2..16.

Ports:
- `clk` input 1: single clock. All logic sits in this domain, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: capture enable. While low, no new entries are pushed; queued entries still drain.
- `tile_out` input 8: observed tile output bus. Asynchronous to `clk`.
- `tx` output 1: serial line. Idle high.
- `busy` output 1: high while a frame is on `tx` or the FIFO is non-empty.
- `overflow` output 1: sticky; set when a change is dropped because the FIFO was full.

## Operation

- Synchroniser: two flops on `tile_out`, producing `sync_q`.
- Change detector:
  - Register `last_q` resets to 0x00.
  - When `ena`=1 and `sync_q` != `last_q`: `last_q` <= `sync_q` and a push of `sync_q` is requested.
  - `last_q` still updates when the push is dropped, so every FIFO entry differs from its predecessor.
  - When `ena`=0, `last_q` holds its value. On re-enable, the next mismatch is pushed.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than `log2(FIFO_DEPTH)`.
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
  - Push when full with no concurrent pop: entry dropped and `overflow` <= 1. `overflow` clears only on reset.
  - Push and pop in the same cycle are both accepted, including when full and when empty with the push bypassed: occupancy is unchanged.
- Transmitter FSM, states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into `shift_q` and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA with bit index 0.
  - DATA: `tx`=`shift_q[idx]`, LSB first, `CLKS_PER_BIT` cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles.
    - On its final cycle, if the FIFO is non-empty, pop and go directly to START, with no idle gap.
    - Otherwise go to IDLE.
- Bit timer: counts 0..`CLKS_PER_BIT`-1 and resets on every state or bit change.
- `busy` = (state != IDLE) | !fifo_empty.

## Timing

- Reset values:
  - Outputs: `tx`=1, `busy`=0, `overflow`=0.
  - Internal: state IDLE, FIFO empty, `last_q`=0x00, both synchroniser stages 0x00.
- Reset assertion mid-frame forces `tx` high immediately (asynchronous) and discards all queued entries.
- Change-to-push latency:
  - `tile_out` change before clk edge 0: `sync_q` valid after edge 1.
  - Push written on edge 2.
  - A change narrower than about 2 clock periods may be missed. This is accepted.
- Push-to-`tx` latency from an empty, idle state:
  - FIFO non-empty after edge 2.
  - Pop and START entry on edge 3, so `tx` falls after edge 3.
- Frame length: exactly 10 x `CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- `busy` rises in the cycle after the push edge. It falls after the final STOP cycle when nothing is queued.
- Sustained change rate above one per frame fills the FIFO. Beyond `FIFO_DEPTH`+1 outstanding values, changes are dropped.

## Structure

- Package `microtile_mon_pkg`:
  - `tx_state_t` enum: IDLE, START, DATA, STOP.
  - Constants `DATA_BITS`=8, `START_LEVEL`=0, `STOP_LEVEL`=1, `IDLE_LEVEL`=1.
- Sub-module `mon_fifo`, parameterised by width and depth:
  - Ports: `push`, `wdata`, `pop`, `rdata`, `full`, `empty`.
  - Contains the pointer logic and the full/empty and same-cycle rules above.
- Top level holds the synchroniser, change detector, transmitter FSM and bit timer.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.

1. Reset, `ena`=1, `tile_out` held at 0x00 for 100 cycles -> `tx` stays 1, `busy`=0, `overflow`=0.
2. `tile_out` 0x00 -> 0xA5, single change:
   - `tx` falls 3 edges later.
   - Bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
   - `busy` low after 40 cycles of frame.
3. Changes 0x01, 0x02, 0x03 applied 5 cycles apart -> three contiguous 40-cycle frames carrying 0x01, 0x02, 0x03 with no idle cycle between them; `overflow`=0.
4. Eight distinct values 10 cycles apart, one frame in flight -> first 5 values transmitted in order, remaining 3 dropped, `overflow`=1 and stays 1 after the line drains.
5. `ena`=0, `tile_out` 0x00 -> 0x3C -> no frame and `busy`=0. `ena`=1 -> exactly one frame carrying 0x3C.
6. Assert `rst_n` low during DATA bit 3 of 0x5A with 2 entries queued:
   - `tx`=1 immediately and `busy`=0.
   - After release, no frame is sent until a new change occurs.
